// File: rtl/enc_pkg.sv
// Shared constants and helpers for the 8-to-3 event encoder.
// prio8 is the single definition of the priority rule; the RTL encoder uses it.
package enc_pkg;

    localparam int N_IN  = 8;
    localparam int N_OUT = 3;

    function automatic logic [N_IN-1:0] onehot3(input logic [N_OUT-1:0] idx);
        logic [N_IN-1:0] one;
        one = {{(N_IN-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Later loop iterations overwrite earlier ones, so the scan direction picks the winner.
    function automatic logic [N_OUT-1:0] prio8(input logic [N_IN-1:0] vec,
                                               input logic            msb_first);
        logic [N_OUT-1:0] r;
        r = '0;
        if (msb_first) begin
            for (int i = 0; i < N_IN; i++) begin
                if (vec[i]) r = N_OUT'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (vec[i]) r = N_OUT'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational priority encoder over the pending vector.
// PRIO_MSB selects whether bit 7 or bit 0 wins.
module prio_enc_8_3
    import enc_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic [N_IN-1:0]  vec_i,
    output logic [N_OUT-1:0] idx_o,
    output logic             any_o
);

    assign idx_o = prio8(vec_i, PRIO_MSB);
    assign any_o = |vec_i;

endmodule

// File: rtl/encoder_8_3.sv
// Sequential 8-to-3 event encoder: captures request pulses into a pending register
// and presents one index at a time on a registered valid/ack output.
module encoder_8_3
    import enc_pkg::*;
#(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             E,
    input  logic [N_IN-1:0]  In,
    input  logic             Ack,
    output logic [N_OUT-1:0] Out,
    output logic             V,
    output logic [N_IN-1:0]  Pend,
    output logic             Ovf
);

    logic [N_IN-1:0]  p_q, p_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic             v_q, v_d;
    logic             ovf_q, ovf_d;

    logic [N_IN-1:0]  cap;
    logic [N_IN-1:0]  moved;
    logic [N_IN-1:0]  prem;
    logic [N_OUT-1:0] sel;
    logic             any;
    logic             load;

    prio_enc_8_3 #(
        .PRIO_MSB (PRIO_MSB)
    ) u_prio (
        .vec_i (p_q),
        .idx_o (sel),
        .any_o (any)
    );

    always_comb begin
        cap   = E ? In : '0;
        load  = ~v_q | Ack;
        moved = '0;
        out_d = out_q;
        v_d   = v_q;

        if (load) begin
            if (any) begin
                moved = onehot3(sel);
                out_d = sel;
                v_d   = 1'b1;
            end else begin
                out_d = '0;
                v_d   = 1'b0;
            end
        end

        // A capture of the bit leaving P this edge is a re-arm, not an overflow.
        prem  = p_q & ~moved;
        p_d   = prem | cap;
        ovf_d = ovf_q | (|(cap & prem));
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            p_q   <= '0;
            out_q <= '0;
            v_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            out_q <= out_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign Out  = out_q;
    assign V    = v_q;
    assign Pend = p_q;
    assign Ovf  = ovf_q;

endmodule

// File: doc/encoder_8_3.md
Name: encoder_8_3

Overview:
- Sequential 8-to-3 event encoder, the inverse of decoder_3_8.
- Captures request pulses on 8 lines into a pending register.
- Presents one index at a time, highest priority first, on a registered 3-bit output with a valid/ack handshake.
- Sits on the return path of decoder_3_8, converting one-hot or multi-hot event lines back to binary indices without dropping simultaneous events.

Parameters:
- PRIO_MSB, 1, 1 = highest set index wins (bit 7 first); 0 = lowest set index wins (bit 0 first).

Ports:
- clka  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- E  input  1  capture enable; In is sampled only when E=1.
- In  input  8  request lines; each set bit is one event per sampled cycle.
- Ack  input  1  consumer accepts current Out; ignored when V=0.
- Out  output  3  registered index of the presented event.
- V  output  1  registered valid for Out.
- Pend  output  8  pending events not yet presented (register P).
- Ovf  output  1  sticky overflow: an event hit an already-pending bit.

Behaviour:
- Reset (rst_n=0 at an edge): P=8'h00, Out=3'b000, V=0, Ovf=0. Reset dominates E, In and Ack. Reset mid-burst discards all pending and presented events.
- cap = E ? In : 8'h00.
- load = ~V | (V & Ack). This is the output slot free or being freed this edge.
- sel = priority-encode(P) per PRIO_MSB. sel is computed from the current P only; cap is never bypassed into the output.
- Edge with load=1 and P!=0:
  - Out<=sel, V<=1.
  - P<=(P & ~onehot(sel)) | cap. The selected bit moves out of P into the output register.
- Edge with load=1 and P==0: V<=0, Out<=3'b000, P<=cap.
- Edge with load=0 (V=1, Ack=0): Out and V hold, P<=P | cap.
- Ovf: set to 1 when (cap & Prem)!=0. Prem is P minus the bit moved out this edge, or all of P if nothing moved.
  - A capture of the bit moved out on the same edge re-arms it cleanly; no Ovf.
  - A capture equal to the currently held Out index sets the P bit; no Ovf.
  - Ovf clears only on reset.
- Latency: In sampled at edge k sets P at k. If the slot is free, V=1 with that index at edge k+1. Minimum latency is 2 edges from input valid to output valid.
- Throughput: one index per cycle while Ack=1 and P!=0.
- Ack with V=0 has no effect.
- Pend = P, direct register output.
- No combinational path from any input to any output.

Decomposition:
- Package enc_pkg: constants N_IN=8 and N_OUT=3.
- Package enc_pkg: function onehot3(idx) returning 8-bit mask.
- Package enc_pkg: function prio8(vec, msb_first) returning 3-bit index.
- Sub-module prio_enc_8_3: purely combinational priority encoder.
  - Inputs: vec[7:0] and PRIO_MSB.
  - Outputs: idx[2:0] and any.
  - Instantiated once; all state lives in encoder_8_3.

Test Plan:
- Reset: rst_n=0 for 3 cycles with E=1, In=8'hFF, Ack=1. Result: Out=0, V=0, Pend=0, Ovf=0 during reset and on the first edge after release.
- Single event: E=1, In=8'h04 for one cycle, Ack=0. Result: Pend=8'h04 at edge k. At k+1, V=1, Out=3'b010, Pend=0. V and Out hold until Ack=1, then V=0 and Out=0 on the next edge.
- Burst, PRIO_MSB=1: In=8'hA5 for one cycle, Ack held 1. Result: Out=7,5,2,0 on consecutive edges with V=1, then V=0. With PRIO_MSB=0 the order is 0,2,5,7.
- Gating: E=0, In=8'hFF for 5 cycles. Result: Pend stays 0, V stays 0, Ovf stays 0.
- Overflow, Ack=0:
  - In=8'h81 captured. Next edge: Out=7, Pend=8'h01.
  - Then In=8'h01: Ovf=1, sticky through further traffic.
  - On a fresh reset, In=8'h80 while Out=7 and V=1: Pend=8'h80, Ovf=0.
- Round trip: decoder_3_8 (E=1, In stepping 0..7, one per cycle) drives In of encoder_8_3, with E=1 and Ack=1. Result: Out reproduces 0..7 with V=1, each index 2 edges after its decoder input, and Ovf=0.
